// File: rtl/sha256_compress_core.sv
// SHA-256 compression round engine: 64 rounds over a..h fed by an external W stream, then H += a..h.
// Optional SHA224_EN adds MODE_224, which selects the SHA-224 IV on START+INIT.
module sha256_compress_core (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic         INIT,
`ifdef SHA224_EN
  input  logic         MODE_224,
`endif
  output logic [5:0]   W_IDX,
  input  logic [31:0]  W_IN,
  input  logic         W_VALID,
  output logic         BUSY,
  output logic         DONE,
  output logic [255:0] H_OUT
);

  localparam logic [255:0] Iv256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
`ifdef SHA224_EN
  localparam logic [255:0] Iv224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
`endif

  localparam logic [31:0] RoundK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [1:0] {StIdle, StLoad, StRound, StFinal} state_e;

  state_e      state_q, state_d;
  logic [31:0] wk_q [8];  // working registers a..h
  logic [31:0] wk_d [8];
  logic [31:0] h_q [8];
  logic [31:0] h_d [8];
  logic [5:0]  t_q, t_d;
  logic        done_q, done_d;
  logic [31:0] t1, t2;
  logic [255:0] iv_sel;

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

`ifdef SHA224_EN
  assign iv_sel = MODE_224 ? Iv224 : Iv256;
`else
  assign iv_sel = Iv256;
`endif

  always_comb begin
    state_d = state_q;
    wk_d    = wk_q;
    h_d     = h_q;
    t_d     = t_q;
    done_d  = 1'b0;
    t1 = wk_q[7] + big_s1(wk_q[4]) + ((wk_q[4] & wk_q[5]) ^ (~wk_q[4] & wk_q[6]))
       + RoundK[t_q] + W_IN;
    t2 = big_s0(wk_q[0]) + ((wk_q[0] & wk_q[1]) ^ (wk_q[0] & wk_q[2]) ^ (wk_q[1] & wk_q[2]));
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d = StLoad;
          if (INIT) begin
            for (int i = 0; i < 8; i++) h_d[i] = iv_sel[255-32*i -: 32];
          end
        end
      end
      StLoad: begin
        wk_d    = h_q;
        t_d     = '0;
        state_d = StRound;
      end
      StRound: begin
        // W_VALID low freezes everything, so stalls of any length are transparent.
        if (W_VALID) begin
          for (int i = 7; i > 0; i--) wk_d[i] = wk_q[i-1];
          wk_d[4] = wk_q[3] + t1;
          wk_d[0] = t1 + t2;
          t_d     = t_q + 6'd1;
          if (t_q == 6'd63) state_d = StFinal;
        end
      end
      StFinal: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wk_q[i];
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      t_q     <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        wk_q[i] <= '0;
        h_q[i]  <= Iv256[255-32*i -: 32];
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= done_d;
      wk_q    <= wk_d;
      h_q     <= h_d;
    end
  end

  assign W_IDX = (state_q == StRound) ? t_q : 6'd0;
  assign BUSY  = (state_q != StIdle);
  assign DONE  = done_q;
  assign H_OUT = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};

endmodule

// File: tb/tb_sha256_compress_core.sv
// Randomised self-checking bench for sha256_compress_core against a plain SHA-256 model.
// Known-answer digests plus random blocks, random stalls, START pokes and mid-block reset.
module tb_sha256_compress_core;

  localparam logic [255:0] Iv256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] Iv224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
  localparam logic [255:0] KatAbc = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] KatEmpty = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] KatTwo = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [223:0] Kat224 = 224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;

  localparam logic [31:0] Kc [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         CLK, RST_N, START, INIT, W_VALID, BUSY, DONE;
  logic         mode_224;
  logic [5:0]   W_IDX;
  logic [31:0]  W_IN;
  logic [255:0] H_OUT;

  logic [31:0]  blk [16];
  logic [31:0]  wsched [64];
  logic [255:0] model_h;
  int           checks, errors;

  sha256_compress_core dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .START   (START),
    .INIT    (INIT),
`ifdef SHA224_EN
    .MODE_224(mode_224),
`endif
    .W_IDX   (W_IDX),
    .W_IN    (W_IN),
    .W_VALID (W_VALID),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .H_OUT   (H_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message schedule as the W-memory would produce it.
  function automatic void expand();
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) wsched[i] = blk[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(wsched[i-15], 7) ^ rotr(wsched[i-15], 18) ^ (wsched[i-15] >> 3);
      s1 = rotr(wsched[i-2], 17) ^ rotr(wsched[i-2], 19) ^ (wsched[i-2] >> 10);
      wsched[i] = wsched[i-16] + s0 + wsched[i-7] + s1;
    end
  endfunction

  function automatic logic [255:0] model_compress(input logic [255:0] hin);
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, x1, x2;
    for (int i = 0; i < 8; i++) hv[i] = hin[255-32*i -: 32];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
    e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int t = 0; t < 64; t++) begin
      x1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + Kc[t] + wsched[t];
      x2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + x1;
      d = c; c = b; b = a; a = x1 + x2;
    end
    return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
            hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
  endfunction

  // Runs one block from blk; abort_at >= 0 pulls reset once that many rounds were accepted.
  task automatic run_block(input string tag, input bit init, input bit m224,
                           input int stall_pct, input bit poke, input int abort_at);
    int edges, stalls, acc, c, widx_bad, hchg_bad;
    bit seen, round;
    logic [255:0] h_start, exp_h;
    mode_224 = m224;
    h_start = init ? (mode_224 ? Iv224 : Iv256) : model_h;
    expand();
    exp_h = model_compress(h_start);
    @(negedge CLK);
    START = 1'b1;
    INIT  = init;
    @(posedge CLK);
    #1;
    edges = 1;
    chk({tag, "_busy_start"}, BUSY, 1);
    chk({tag, "_done_pulse"}, DONE, 0);
    @(negedge CLK);
    START = 1'b0;
    INIT  = 1'b0;
    acc = 0; stalls = 0; c = 1; seen = 0; widx_bad = 0; hchg_bad = 0;
    while (!seen && edges < 2000) begin
      if (W_IDX !== acc[5:0]) widx_bad++;
      if (H_OUT !== h_start) hchg_bad++;
      round = (c >= 2) && (acc < 64);
      if (abort_at >= 0 && round && acc == abort_at) begin
        START = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        chk({tag, "_abort_busy"}, BUSY, 0);
        chk({tag, "_abort_done"}, DONE, 0);
        chk({tag, "_abort_h"}, H_OUT, Iv256);
        chk({tag, "_abort_widx"}, W_IDX, 0);
        chk({tag, "_widx_track"}, widx_bad, 0);
        @(negedge CLK);
        RST_N   = 1'b1;
        W_VALID = 1'b0;
        model_h = Iv256;
        return;
      end
      W_VALID = round ? ($urandom_range(99) >= stall_pct) : 1'($urandom_range(1));
      W_IN    = (round && W_VALID) ? wsched[acc[5:0]] : $urandom;
      START   = poke && round && ($urandom_range(3) == 0);
      INIT    = START;
      @(posedge CLK);
      #1;
      edges++;
      c++;
      if (round) begin
        if (W_VALID) acc++;
        else stalls++;
      end
      seen = DONE;
      @(negedge CLK);
    end
    START = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_latency"}, edges, 67 + stalls);
    chk({tag, "_digest"}, H_OUT, exp_h);
    chk({tag, "_widx_track"}, widx_bad, 0);
    chk({tag, "_h_stable"}, hchg_bad, 0);
    chk({tag, "_idle_busy"}, BUSY, 0);
    model_h = exp_h;
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  initial begin
    checks = 0; errors = 0;
    RST_N = 1'b0; START = 1'b0; INIT = 1'b0; W_VALID = 1'b0; W_IN = '0; mode_224 = 1'b0;
    model_h = Iv256;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_widx", W_IDX, 0);
    chk("rst_h", H_OUT, Iv256);
    @(negedge CLK);
    RST_N = 1'b1;

    load_abc();
    run_block("abc", 1, 0, 0, 0, -1);
    chk("abc_kat", H_OUT, KatAbc);

    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0] = 32'h80000000;
    run_block("empty", 1, 0, 0, 0, -1);
    chk("empty_kat", H_OUT, KatEmpty);

    load_abc();
    run_block("abc_stall", 1, 0, 50, 0, -1);
    chk("abc_stall_kat", H_OUT, KatAbc);

    blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    run_block("two_b1", 1, 0, 10, 0, -1);
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[15] = 32'h000001c0;
    run_block("two_b2", 0, 0, 10, 0, -1);
    chk("two_kat", H_OUT, KatTwo);

    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    run_block("poke", 0, 0, 20, 1, -1);

    load_abc();
    run_block("abort", 1, 0, 30, 0, 30);
    load_abc();
    run_block("abc_again", 1, 0, 0, 0, -1);
    chk("abc_again_kat", H_OUT, KatAbc);

`ifdef SHA224_EN
    load_abc();
    run_block("abc224", 1, 1, 0, 0, -1);
    chk("abc224_kat", {32'h0, H_OUT[255:32]}, {32'h0, Kat224});
`endif

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      run_block("rand", 1'($urandom_range(1)), 0, int'($urandom_range(60)),
                1'($urandom_range(1)), -1);
    end

    @(posedge CLK);
    #1;
    chk("done_one_cycle", DONE, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
